// File: rtl/td4_pkg.sv
// Shared constants for the TD4 control sequencer: opcodes, ALU source
// select encoding and the two-state FETCH/EXEC encoding.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'h0;
  localparam logic [3:0] OP_MOV_AB = 4'h1;
  localparam logic [3:0] OP_IN_A   = 4'h2;
  localparam logic [3:0] OP_MOV_A  = 4'h3;
  localparam logic [3:0] OP_MOV_BA = 4'h4;
  localparam logic [3:0] OP_ADD_B  = 4'h5;
  localparam logic [3:0] OP_IN_B   = 4'h6;
  localparam logic [3:0] OP_MOV_B  = 4'h7;
  localparam logic [3:0] OP_OUT_B  = 4'h9;
  localparam logic [3:0] OP_OUT_IM = 4'hB;
  localparam logic [3:0] OP_JNC    = 4'hE;
  localparam logic [3:0] OP_JMP    = 4'hF;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_IN   = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

endpackage

// File: rtl/td4_decoder.sv
// Combinational instruction decoder: maps the instruction register and carry
// flag to ALU select, immediate, active-low chip selects and PC load.
module td4_decoder
  import td4_pkg::*;
#(
  parameter int bitWidth = 4
) (
  input  logic [bitWidth+3:0] ir,
  input  logic                cf,
  input  logic                exec,
  output logic [1:0]          sel,
  output logic [bitWidth-1:0] imm,
  output logic                cs_a,
  output logic                cs_b,
  output logic                cs_out,
  output logic                cs_pc,
  output logic                pc_load
);

  logic [3:0] opcode;

  assign opcode = ir[bitWidth+3:bitWidth];
  assign imm    = ir[bitWidth-1:0];

  always_comb begin
    sel     = SEL_A;
    cs_a    = 1'b1;
    cs_b    = 1'b1;
    cs_out  = 1'b1;
    cs_pc   = 1'b1;
    pc_load = 1'b0;
    if (exec) begin
      // Every executed instruction advances or loads the PC.
      cs_pc = 1'b0;
      sel   = SEL_ZERO;
      case (opcode)
        OP_ADD_A:  begin sel = SEL_A;    cs_a   = 1'b0; end
        OP_ADD_B:  begin sel = SEL_B;    cs_b   = 1'b0; end
        OP_MOV_A:  begin sel = SEL_ZERO; cs_a   = 1'b0; end
        OP_MOV_B:  begin sel = SEL_ZERO; cs_b   = 1'b0; end
        OP_MOV_AB: begin sel = SEL_B;    cs_a   = 1'b0; end
        OP_MOV_BA: begin sel = SEL_A;    cs_b   = 1'b0; end
        OP_IN_A:   begin sel = SEL_IN;   cs_a   = 1'b0; end
        OP_IN_B:   begin sel = SEL_IN;   cs_b   = 1'b0; end
        OP_OUT_B:  begin sel = SEL_B;    cs_out = 1'b0; end
        OP_OUT_IM: begin sel = SEL_ZERO; cs_out = 1'b0; end
        OP_JMP:    begin sel = SEL_ZERO; pc_load = 1'b1; end
        OP_JNC:    begin sel = SEL_ZERO; pc_load = ~cf;  end
        default:   sel = SEL_ZERO;
      endcase
    end
  end

endmodule

// File: rtl/td4_sequencer.sv
// Two-state FETCH/EXEC sequencer for the TD4 CPU; owns IR and the carry flag.
// Optional single-step gating is enabled by defining TD4_SINGLE_STEP_EN.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int bitWidth = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [bitWidth+3:0] INSTR,
  input  logic                C_ALU,
`ifdef TD4_SINGLE_STEP_EN
  input  logic                STEP,
`endif
  output logic [1:0]          SEL,
  output logic [bitWidth-1:0] IMM,
  output logic                CS_A,
  output logic                CS_B,
  output logic                CS_OUT,
  output logic                CS_PC,
  output logic                PC_LOAD,
  output logic                FETCH,
  output logic                CF
);

  state_t              state;
  state_t              next_state;
  logic [bitWidth+3:0] ir;
  logic                cf_q;
  logic                advance;
  logic                exec_active;

`ifdef TD4_SINGLE_STEP_EN
  assign advance = STEP;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (!CLR) state <= ST_FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH: next_state = advance ? ST_EXEC : ST_FETCH;
      ST_EXEC:  next_state = ST_FETCH;
      default:  next_state = ST_FETCH;
    endcase
  end

  // IR loads only on an advancing FETCH edge; CF follows the ALU on every EXEC edge.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      ir   <= '0;
      cf_q <= 1'b0;
    end else begin
      if (state == ST_FETCH && advance) ir <= INSTR;
      if (state == ST_EXEC) cf_q <= C_ALU;
    end
  end

  // A low CLR masks EXEC so the cleared cycle asserts no chip select.
  always_comb begin
    exec_active = (state == ST_EXEC) && CLR;
    FETCH       = (state == ST_FETCH) || !CLR;
    CF          = cf_q;
  end

  td4_decoder #(.bitWidth(bitWidth)) u_decoder (
    .ir      (ir),
    .cf      (cf_q),
    .exec    (exec_active),
    .sel     (SEL),
    .imm     (IMM),
    .cs_a    (CS_A),
    .cs_b    (CS_B),
    .cs_out  (CS_OUT),
    .cs_pc   (CS_PC),
    .pc_load (PC_LOAD)
  );

endmodule

// File: tb/tb_td4_sequencer.sv
// Self-checking bench for td4_sequencer: directed decode cases, randomized
// instruction stream against a table-driven model, reset and single-step.
module tb_td4_sequencer;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] INSTR = 8'h00;
  logic       C_ALU = 1'b0;
  logic       STEP = 1'b1;
  logic [1:0] SEL;
  logic [3:0] IMM;
  logic       CS_A, CS_B, CS_OUT, CS_PC, PC_LOAD, FETCH, CF;

  int tests = 0;
  int fails = 0;

  // Reference state: carry flag as the architecture defines it.
  logic model_cf = 1'b0;
  logic [10:0] exp_q[$];

  // Decode table from the instruction set: source select, destination
  // (0 none, 1 A, 2 B, 3 OUT), jump kind (0 none, 1 always, 2 if no carry).
  logic [1:0] tbl_sel[16];
  int         tbl_dst[16];
  int         tbl_jmp[16];

  td4_sequencer #(.bitWidth(4)) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .INSTR   (INSTR),
    .C_ALU   (C_ALU),
`ifdef TD4_SINGLE_STEP_EN
    .STEP    (STEP),
`endif
    .SEL     (SEL),
    .IMM     (IMM),
    .CS_A    (CS_A),
    .CS_B    (CS_B),
    .CS_OUT  (CS_OUT),
    .CS_PC   (CS_PC),
    .PC_LOAD (PC_LOAD),
    .FETCH   (FETCH),
    .CF      (CF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic init_table();
    for (int i = 0; i < 16; i++) begin
      tbl_sel[i] = 2'd3; tbl_dst[i] = 0; tbl_jmp[i] = 0;
    end
    tbl_sel[4'h0] = 2'd0; tbl_dst[4'h0] = 1;
    tbl_sel[4'h5] = 2'd1; tbl_dst[4'h5] = 2;
    tbl_sel[4'h3] = 2'd3; tbl_dst[4'h3] = 1;
    tbl_sel[4'h7] = 2'd3; tbl_dst[4'h7] = 2;
    tbl_sel[4'h1] = 2'd1; tbl_dst[4'h1] = 1;
    tbl_sel[4'h4] = 2'd0; tbl_dst[4'h4] = 2;
    tbl_sel[4'h2] = 2'd2; tbl_dst[4'h2] = 1;
    tbl_sel[4'h6] = 2'd2; tbl_dst[4'h6] = 2;
    tbl_sel[4'h9] = 2'd1; tbl_dst[4'h9] = 3;
    tbl_sel[4'hB] = 2'd3; tbl_dst[4'hB] = 3;
    tbl_jmp[4'hF] = 1;
    tbl_jmp[4'hE] = 2;
  endtask

  // Expected EXEC outputs packed as {SEL, CS_A, CS_B, CS_OUT, CS_PC, PC_LOAD, IMM}.
  function automatic logic [10:0] model_vec(input logic [7:0] ins, input logic cf);
    int  op;
    int  dst;
    logic jump;
    op   = int'(ins[7:4]);
    dst  = tbl_dst[op];
    jump = (tbl_jmp[op] == 1) || (tbl_jmp[op] == 2 && !cf);
    return {tbl_sel[op], dst != 1, dst != 2, dst != 3, 1'b0, jump, ins[3:0]};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {SEL, CS_A, CS_B, CS_OUT, CS_PC, PC_LOAD, IMM};
  endfunction

  // Idle bits packed as {CS_A, CS_B, CS_OUT, CS_PC, PC_LOAD, FETCH}.
  function automatic logic [5:0] idle_vec();
    return {CS_A, CS_B, CS_OUT, CS_PC, PC_LOAD, FETCH};
  endfunction

  task automatic do_fetch(input logic [7:0] ins);
    INSTR = ins;
    @(posedge CLK); #2;
  endtask

  task automatic do_exec(input logic c);
    C_ALU = c;
    @(posedge CLK); #2;
    model_cf = c;
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    INSTR = 8'hF7;
    C_ALU = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    tests++;
    if (idle_vec() !== 6'b111101 || SEL !== 2'd0) begin
      fails++;
      $display("FAIL reset_outputs: got idle=%b sel=%0d, want idle=111101 sel=0", idle_vec(), SEL);
    end
    tests++;
    if (CF !== 1'b0 || IMM !== 4'h0) begin
      fails++;
      $display("FAIL reset_state: got cf=%b imm=%h, want cf=0 imm=0", CF, IMM);
    end
    CLR = 1'b1;
    model_cf = 1'b0;
    do_fetch(8'h35);
    tests++;
    if (FETCH !== 1'b0) begin
      fails++;
      $display("FAIL first_edge_exec: got fetch=%b, want 0", FETCH);
    end
    do_exec(1'b0);
  endtask

  task automatic test_directed();
    logic [7:0] prog[10];
    logic       carry[10];
    prog  = '{8'h35, 8'h0F, 8'hE7, 8'hE9, 8'hF2, 8'h90, 8'hB6, 8'h20, 8'h80, 8'h1C};
    carry = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      logic [10:0] exp;
      exp = model_vec(prog[i], model_cf);
      do_fetch(prog[i]);
      tests++;
      if (obs_vec() !== exp || FETCH !== 1'b0) begin
        fails++;
        $display("FAIL directed_exec[%02h]: got %b fetch=%b, want %b fetch=0", prog[i], obs_vec(), FETCH, exp);
      end
      do_exec(carry[i]);
      tests++;
      if (CF !== model_cf || idle_vec() !== 6'b111101) begin
        fails++;
        $display("FAIL directed_fetch[%02h]: got cf=%b idle=%b, want cf=%b idle=111101", prog[i], CF, idle_vec(), model_cf);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      logic [7:0]  ins;
      logic        c;
      logic [10:0] exp;
      ins = 8'($urandom_range(0, 255));
      c   = 1'($urandom_range(0, 1));
      exp_q.push_back(model_vec(ins, model_cf));
      do_fetch(ins);
      exp = exp_q.pop_front();
      tests++;
      if (obs_vec() !== exp) begin
        fails++;
        $display("FAIL random_exec[%0d] ins=%02h: got %b, want %b", i, ins, obs_vec(), exp);
      end
      do_exec(c);
      tests++;
      if (CF !== model_cf || FETCH !== 1'b1) begin
        fails++;
        $display("FAIL random_cf[%0d]: got cf=%b fetch=%b, want cf=%b fetch=1", i, CF, FETCH, model_cf);
      end
    end
  endtask

  task automatic test_clr_mid_exec();
    logic [10:0] exp;
    do_fetch(8'h0F);
    do_exec(1'b1);
    do_fetch(8'h35);
    CLR = 1'b0;
    C_ALU = 1'b1;
    #1;
    tests++;
    if (idle_vec() !== 6'b111101 || SEL !== 2'd0) begin
      fails++;
      $display("FAIL clr_exec_outputs: got idle=%b sel=%0d, want idle=111101 sel=0", idle_vec(), SEL);
    end
    @(posedge CLK); #2;
    model_cf = 1'b0;
    tests++;
    if (CF !== 1'b0 || FETCH !== 1'b1 || IMM !== 4'h0) begin
      fails++;
      $display("FAIL clr_exec_state: got cf=%b fetch=%b imm=%h, want cf=0 fetch=1 imm=0", CF, FETCH, IMM);
    end
    CLR = 1'b1;
    #1;
    exp = model_vec(8'hE4, model_cf);
    do_fetch(8'hE4);
    tests++;
    if (obs_vec() !== exp) begin
      fails++;
      $display("FAIL clr_resume: got %b, want %b", obs_vec(), exp);
    end
    do_exec(1'b0);
  endtask

`ifdef TD4_SINGLE_STEP_EN
  task automatic test_step();
    logic [10:0] exp;
    do_fetch(8'h3A);
    do_exec(1'b1);
    STEP = 1'b0;
    INSTR = 8'hB6;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #2;
      tests++;
      if (FETCH !== 1'b1 || IMM !== 4'hA || idle_vec() !== 6'b111101 || CF !== 1'b1) begin
        fails++;
        $display("FAIL step_hold[%0d]: got fetch=%b imm=%h idle=%b cf=%b, want fetch=1 imm=a idle=111101 cf=1", i, FETCH, IMM, idle_vec(), CF);
      end
    end
    STEP = 1'b1;
    exp = model_vec(8'hB6, model_cf);
    @(posedge CLK); #2;
    tests++;
    if (FETCH !== 1'b0 || obs_vec() !== exp) begin
      fails++;
      $display("FAIL step_advance: got fetch=%b vec=%b, want fetch=0 vec=%b", FETCH, obs_vec(), exp);
    end
    do_exec(1'b0);
  endtask
`endif

  initial begin
    init_table();
    test_reset();
    test_directed();
    test_clr_mid_exec();
`ifdef TD4_SINGLE_STEP_EN
    test_step();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
